// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
//   SZ_*    : req_size encodings (2'b11 is illegal)
//   state_e : responder FSM states
//   CNT_W   : wait-state counter width
//   dreq_t  : request fields latched at acceptance
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: core <-> data-memory handshake bundle.
//   master : core side (drives request, receives response)
//   slave  : responder side
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane logic for one access.
//   size/lane/uns : access size, byte offset within word, zero-extend flag
//   wdata         : right-aligned store data
//   old_word      : current array word
//   be            : byte-write enables
//   wword         : old_word with enabled lanes replaced by store data
//   rdata         : extracted + extended load value
//   misalign      : half on odd lane or word on nonzero lane
module dmem_lane import dmem_pkg::*; (
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [31:0] shifted;
  logic [31:0] wrep;

  always_comb begin
    be       = '0;
    wrep     = wdata;
    rdata    = '0;
    misalign = 1'b0;
    wword    = old_word;
    shifted  = old_word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wrep  = {4{wdata[7:0]}};
        rdata = uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be       = 4'b0011 << lane;
        wrep     = {2{wdata[15:0]}};
        rdata    = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misalign = lane[0];
      end
      SZ_WORD: begin
        be       = 4'hF;
        rdata    = old_word;
        misalign = |lane;
      end
      default: ;
    endcase
    // Store data is replicated across lanes so the enable alone picks the target bytes.
    for (int i = 0; i < 4; i++)
      if (be[i]) wword[i*8 +: 8] = wrep[i*8 +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the RV32I data-access interface.
//   clk, rst : clock, async active-high reset
//   bus      : dmem_if.slave -- valid/ready request, one-cycle response strobe
// Requests are latched in IDLE, held for WAIT_CYCLES wait states, and the
// array is accessed on the edge entering RESP (store commit + registered load).
module dmem_responder import dmem_pkg::*; #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  dmem_if.slave bus
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             enter_resp;
  dreq_t            req_q, cur;
  logic [31:0]      offset;
  logic [AW-1:0]    widx;
  logic [31:0]      old_word, wword, ld_data;
  logic [3:0]       be;
  logic             misalign, err;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0] mem [DEPTH_WORDS];

  assign bus.req_ready = (state == S_IDLE) & ~rst;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: if (bus.req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access must use the live request rather than the latched copy.
  always_comb begin
    if (state == S_IDLE)
      cur = '{write: bus.req_write, size: bus.req_size, uns: bus.req_unsigned,
              addr: bus.req_addr, wdata: bus.req_wdata};
    else
      cur = req_q;
  end

  assign offset   = cur.addr - BASE_ADDR;
  assign widx     = offset[AW+1:2];
  assign old_word = mem[widx];

  dmem_lane u_lane (
    .size     (cur.size),
    .lane     (offset[1:0]),
    .uns      (cur.uns),
    .wdata    (cur.wdata),
    .old_word (old_word),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_data),
    .misalign (misalign)
  );

  assign err = misalign | (cur.size == 2'b11) | ({1'b0, offset} >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && bus.req_valid) req_q <= cur;
      if (enter_resp) begin
        rdata_q <= (err | cur.write) ? 32'h0 : ld_data;
        err_q   <= err;
      end
    end
  end

  // Array is not reset; rst gating drops a store whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur.write && !err && (|be))
      mem[widx] <= wword;
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int W_A = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if ba ();
  dmem_if bb ();

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W_A), .BASE_ADDR(32'h0))
    dut_a (.clk(clk), .rst(rst), .bus(ba));
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0))
    dut_b (.clk(clk), .rst(rst), .bus(bb));

  int checks = 0;
  int errors = 0;

  // byte-addressed reference memory, 4 KiB
  logic [7:0] mb [4096];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: offset checks by arithmetic, data assembled byte by byte.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
    logic [31:0] off;
    logic [31:0] v;
    int n;
    off = addr;
    n   = (sz == 2'b11) ? 0 : (1 << sz);
    e   = (sz == 2'b11) || (off >= 32'd4096) || (n > 1 && (off % n) != 0);
    rd  = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[off + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[off + i]) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
        rd = v;
      end
    end
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e);
    logic [31:0] mrd;
    logic        me;
    int n;
    @(negedge clk);
    ba.req_write = w; ba.req_size = sz; ba.req_unsigned = u;
    ba.req_addr = addr; ba.req_wdata = wd; ba.req_valid = 1'b1;
    n = 0;
    while (!ba.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", {31'b0, ba.req_ready}, 32'd1);
    @(posedge clk); #1;
    // garbage while busy must be ignored
    ba.req_valid = 1'b0; ba.req_write = 1'($urandom); ba.req_size = 2'($urandom);
    ba.req_unsigned = 1'($urandom); ba.req_addr = $urandom; ba.req_wdata = $urandom;
    model(w, sz, u, addr, wd, mrd, me);
    @(negedge clk);
    n = 0;
    while (!ba.rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'(W_A));
    rd = ba.rsp_rdata;
    e  = ba.rsp_err;
    chk("rdata", rd, mrd);
    chk("err", {31'b0, e}, {31'b0, me});
    @(negedge clk);
    chk("rsp_one_cycle", {31'b0, ba.rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [31:0] addr;
    logic [1:0]  sz;
    int r;
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    ba.req_valid = 0; ba.req_write = 0; ba.req_size = 0; ba.req_unsigned = 0;
    ba.req_addr = 0; ba.req_wdata = 0;
    bb.req_valid = 0; bb.req_write = 0; bb.req_size = 0; bb.req_unsigned = 0;
    bb.req_addr = 0; bb.req_wdata = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ba.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, ba.rsp_valid}, 32'd0);
    chk("rst_rdata", ba.rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, ba.rsp_err}, 32'd0);
    rst = 1'b0;
    #1 chk("rel_ready", {31'b0, ba.req_ready}, 32'd1);

    // zero the words used below (array contents are not reset)
    for (int i = 0; i < 16; i++) xact(1, 2'b10, 0, 32'(i*4), 32'h0, rd, e);
    for (int i = 1020; i < 1024; i++) xact(1, 2'b10, 0, 32'(i*4), 32'h0, rd, e);

    // directed sequence
    xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, e);
    xact(0, 2'b10, 0, 32'h10, 32'h0, rd, e);  chk("lw_10", rd, 32'hDEADBEEF);
    xact(1, 2'b00, 0, 32'h11, 32'h0000005A, rd, e);
    xact(0, 2'b00, 0, 32'h13, 32'h0, rd, e);  chk("lb_13", rd, 32'hFFFFFFDE);
    xact(0, 2'b00, 1, 32'h11, 32'h0, rd, e);  chk("lbu_11", rd, 32'h0000005A);
    xact(0, 2'b01, 0, 32'h10, 32'h0, rd, e);  chk("lh_10", rd, 32'h00005AEF);
    xact(0, 2'b01, 0, 32'h11, 32'h0, rd, e);  chk("lh_11_err", {31'b0, e}, 32'd1);
    xact(0, 2'b10, 0, 32'h12, 32'h0, rd, e);  chk("lw_12_err", {31'b0, e}, 32'd1);
    xact(0, 2'b11, 0, 32'h10, 32'h0, rd, e);  chk("sz11_err", {31'b0, e}, 32'd1);
    xact(1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, rd, e); chk("oor_err", {31'b0, e}, 32'd1);
    xact(0, 2'b10, 0, 32'h0, 32'h0, rd, e);   chk("no_wrap", rd, 32'h0);
    xact(0, 2'b10, 0, 32'hFFC, 32'h0, rd, e); chk("ffc_ok", {31'b0, e}, 32'd0);
    xact(0, 2'b10, 0, 32'h10, 32'h0, rd, e);  chk("lw_10b", rd, 32'hDEAD5AEF);

    // reset during WAIT of a store to 0x20
    @(negedge clk);
    ba.req_write = 1; ba.req_size = 2'b10; ba.req_unsigned = 0;
    ba.req_addr = 32'h20; ba.req_wdata = 32'h12345678; ba.req_valid = 1;
    @(posedge clk); #1 ba.req_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wrst_ready", {31'b0, ba.req_ready}, 32'd0);
    chk("wrst_rsp_valid", {31'b0, ba.rsp_valid}, 32'd0);
    chk("wrst_rdata", ba.rsp_rdata, 32'd0);
    chk("wrst_err", {31'b0, ba.rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("wrst_idle", {31'b0, ba.req_ready}, 32'd1);
    xact(0, 2'b10, 0, 32'h20, 32'h0, rd, e);  chk("lw_20", rd, 32'h0);

    // randomized traffic against the reference model
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 15);
      sz = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      r = $urandom_range(0, 9);
      if (r < 6)      addr = 32'($urandom_range(0, 63));
      else if (r < 8) addr = 32'hFF0 + 32'($urandom_range(0, 15));
      else if (r < 9) addr = 32'h1000 + 32'($urandom_range(0, 15));
      else            addr = $urandom;
      xact(1'($urandom), sz, 1'($urandom), addr, $urandom, rd, e);
    end

    // zero wait states: req_valid held high, accept every second cycle
    @(negedge clk);
    bb.req_write = 1; bb.req_size = 2'b10; bb.req_addr = 32'h0;
    bb.req_wdata = 32'h0; bb.req_valid = 1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", {31'b0, bb.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b_rsp", {31'b0, bb.rsp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    bb.req_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the core's data-access interface. It accepts load/store requests (data address from the ALU result, store data from register port 2) through a valid/ready handshake, stalls for a configurable number of wait states, and returns the load data to the core's read-data input. Byte, halfword and word accesses are supported, with sign/zero extension on loads and byte-lane merging on stores. Misaligned or out-of-range accesses are flagged, not performed.

## Interface
- DEPTH_WORDS, 1024: storage size in 32-bit words (power of two).
- WAIT_CYCLES, 1: wait states between acceptance and response, 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU).
- req_addr  in  32  byte address (DAD).
- req_wdata  in  32  store data, right-aligned (DDT write side).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data (ReadDDT); 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: misaligned, out of range, or illegal size.

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid, latch write/size/unsigned/addr/wdata; go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
- WAIT: req_ready=0; counter decrements each cycle; at 0 go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; next state IDLE unconditionally.
- Array access happens on the edge that enters RESP: the store commits, and the load word is read and registered into rsp_rdata.
- Offset = addr - BASE_ADDR; word index = offset[log2(DEPTH_WORDS)+1:2]; lane = offset[1:0].
- Error when: size=11; half with lane[0]=1; word with lane≠0; offset ≥ 4*DEPTH_WORDS (unsigned). On error: no write, rsp_rdata=0, rsp_err=1.
- Store: byte writes lane ← wdata[7:0]; half writes lanes {lane+1,lane} ← wdata[15:0]; word writes all lanes. All other bytes are untouched.
- Load: extract the byte/half at lane into bits [7:0]/[15:0]; sign-extend from bit 7/15 unless req_unsigned. Word loads ignore req_unsigned.
- Store response: rsp_rdata=0, rsp_err per the checks.
- Array contents are not reset. Unwritten contents are undefined; simulation initialises them to 0.

## Timing
- Request accepted at edge k (req_valid & req_ready). rsp_valid is high in the cycle after edge k+WAIT_CYCLES. The next acceptance is possible at edge k+WAIT_CYCLES+2.
- Request fields are sampled only at acceptance. Changes while busy are ignored.
- req_valid low in IDLE: no state change. req_valid held through RESP is accepted again only after returning to IDLE; the core must drop it after rsp_valid.
- Reset values: req_ready=1 after release (0 while rst=1), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset asserted in WAIT drops the pending store. Reset asserted on the same edge as RESP entry suppresses the write.
- Consecutive store then load to the same address returns the new data: the store commits before the later acceptance.

## Structure
- Shared package dmem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum (S_IDLE, S_WAIT, S_RESP), WAIT counter width constant (4).
- Sub-module dmem_lane (combinational): given size, lane, unsigned flag, wdata and the old word, produce the 4-bit byte-write enable, the merged store word, the extended load value and the misalign flag. FSM, counter and array stay in dmem_responder.

## Test plan
- WAIT_CYCLES=2; store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_valid exactly 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
- After the above: store byte 0x5A at 0x11; load byte signed at 0x13 -> 0xFFFFFFDE; load byte unsigned at 0x11 -> 0x0000005A; load half signed at 0x10 -> 0x00005AEF.
- Load half at 0x11, load word at 0x12, req_size=11 -> each err=1, rdata 0; a following word load at 0x10 still returns 0xDEAD5AEF.
- DEPTH_WORDS=1024: store at 0x1000 -> err=1 with no wrap into word 0; load at 0xFFC -> err 0.
- WAIT_CYCLES=0: back-to-back requests with req_valid held high -> accepts every 2nd cycle, req_ready low during RESP.
- Assert rst during WAIT of a store to 0x20 -> outputs 0 immediately, state IDLE; a later load of 0x20 returns the prior value (0).
